// File: rtl/sum_accumulator_32_pkg.sv
// Shared definitions for the packet summation stage.
//   DATA_W  : datapath width of words and sums
//   state_t : ACCUM (taking beats) / HOLD (presenting a finished result)
package sum_accumulator_32_pkg;
  localparam int DATA_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/sum_accumulator_32_adder.sv
// Adder_32: pure combinational 32-bit adder, no carry-out.
//   A, B : operands
//   S    : A + B mod 2**32
module Adder_32
  import sum_accumulator_32_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] S
);
  assign S = A + B;
endmodule

// File: rtl/sum_accumulator_32.sv
// sum_accumulator_32: sums a valid/ready stream of 32-bit words per packet and
// presents one registered {sum, count, ovf} result per packet.
//   clk, rst             : clock, synchronous active-high reset
//   clr                  : abort packet in progress (ignored in HOLD)
//   in_valid/in_ready    : input handshake; in_data word, in_last ends packet
//   out_valid/out_ready  : result handshake
//   out_sum              : packet sum mod 2**32
//   out_count            : beats in packet, saturating at 2**CNT_W-1
//   out_ovf              : at least one carry out of bit 31 in the packet
module sum_accumulator_32
  import sum_accumulator_32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);
  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  sum;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               ovf;
  logic               carry;
  logic               beat;

  Adder_32 u_add (
    .A (acc),
    .B (in_data),
    .S (sum)
  );

  // Adder has no carry-out; a wrapped unsigned sum is smaller than either operand.
  assign carry     = (sum < acc);
  assign count_nxt = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
  assign in_ready  = (state == ACCUM) & ~clr;
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          out_valid <= 1'b0;
          if (clr) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else if (beat) begin
            if (in_last) begin
              // Commit result and start the next packet from zero.
              out_sum   <= sum;
              out_count <= count_nxt;
              out_ovf   <= ovf | carry;
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc   <= sum;
              count <= count_nxt;
              ovf   <= ovf | carry;
            end
          end
        end
        HOLD: begin
          // No bypass: the next packet starts the cycle after the handoff.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
